// File: rtl/instr_mem_fetch_if.sv
// Fetch-port bundle between the fetch stage (master) and instr_mem_fetch (slave).
interface instr_mem_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/instr_mem_fetch.sv
// Instruction memory with buffered valid/ready fetch port, program-load port and flush.
// Define IMEM_RANGE_CHECK_EN to flag out-of-range fetches (rsp_err) and drop out-of-range loads.
module instr_mem_fetch #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 8,
  parameter int BUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              flush,
  instr_mem_fetch_if.slave  fetch
);

`ifdef IMEM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  ld_idx;
  logic              rd_in_range;
  logic              ld_in_range;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;

  logic [DATA_W-1:0] fifo_data [BUF_DEPTH];
  logic              fifo_err  [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  cnt;

  logic              head_valid;
  logic              accept;
  logic              pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Without range checking, addresses alias modulo DEPTH through truncation.
  assign rd_idx      = IDX_W'(fetch.req_addr);
  assign ld_idx      = IDX_W'(ld_addr);
  assign rd_in_range = !RANGE_CHECK || ({1'b0, fetch.req_addr} < DEPTH_A);
  assign ld_in_range = !RANGE_CHECK || ({1'b0, ld_addr} < DEPTH_A);

  assign head_valid      = (fifo_cnt != '0);
  assign fetch.req_ready = rst_n & ~ld_en & ~flush & (cnt < FULL_CNT);
  assign fetch.rsp_valid = head_valid;
  assign fetch.rsp_data  = head_valid ? fifo_data[rd_ptr] : '0;
  assign fetch.rsp_err   = RANGE_CHECK & head_valid & fifo_err[rd_ptr];

  assign accept = fetch.req_valid & fetch.req_ready;
  assign pop    = head_valid & fetch.rsp_ready;

  always_ff @(posedge clk) begin
    if (ld_en && ld_in_range)
      mem[ld_idx] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else if (flush) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        rd_data <= rd_in_range ? mem[rd_idx] : '0;
        rd_err  <= ~rd_in_range;
      end
    end
  end

  // Credit counting guarantees a free slot whenever the read stage pushes.
  always_ff @(posedge clk) begin
    if (rd_valid) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_err[wr_ptr]  <= rd_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rd_valid)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({rd_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Bench for instr_mem_fetch: directed table, hand-written corner sequences and a
// randomized phase, all checked against a queue-based reference model.
module tb_instr_mem_fetch;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 8;
  localparam int BUF_DEPTH = 3;
`ifdef IMEM_RANGE_CHECK_EN
  localparam int DEPTH       = 48;
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam int DEPTH       = 64;
  localparam bit RANGE_CHECK = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        ld_en   = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [31:0] ld_data = 32'd0;
  logic        flush   = 1'b0;

  instr_mem_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_fetch #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .flush   (flush),
    .fetch   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: every accepted fetch waits in a queue until popped; it becomes
  // visible two cycles after acceptance and the queue length is the credit count.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          avail;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  logic        exp_ready;
  logic        exp_valid;
  logic        exp_err;
  logic [31:0] exp_data;

  typedef struct {
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        req_valid;
    logic [7:0]  req_addr;
    logic        rsp_ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mkv(input logic l, input logic [7:0] la, input logic [31:0] ldd,
                               input logic rv, input logic [7:0] ra, input logic rr,
                               input logic er, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.ld_en = l; v.ld_addr = la; v.ld_data = ldd;
    v.req_valid = rv; v.req_addr = ra; v.rsp_ready = rr;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic cmp1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic cmp32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic checkOutput();
    if (!rst_n) q.delete();
    exp_ready = rst_n && !ld_en && !flush && (q.size() < BUF_DEPTH);
    exp_valid = (q.size() > 0) && (q[0].avail <= cyc);
    exp_data  = exp_valid ? q[0].data : 32'd0;
    exp_err   = exp_valid ? q[0].err : 1'b0;
    cmp1("model_req_ready", bus.req_ready, exp_ready);
    cmp1("model_rsp_valid", bus.rsp_valid, exp_valid);
    cmp32("model_rsp_data", bus.rsp_data, exp_data);
    cmp1("model_rsp_err", bus.rsp_err, exp_err);
  endtask

  task automatic modelEdge();
    rsp_t r;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (exp_valid && bus.rsp_ready) void'(q.pop_front());
      if (exp_ready && bus.req_valid) begin
        if (RANGE_CHECK && (int'(bus.req_addr) >= DEPTH)) begin
          r.data = 32'd0;
          r.err  = 1'b1;
        end else begin
          r.data = mem_m[int'(bus.req_addr) % DEPTH];
          r.err  = 1'b0;
        end
        r.avail = cyc + 2;
        q.push_back(r);
      end
    end
    if (ld_en && (!RANGE_CHECK || (int'(ld_addr) < DEPTH)))
      mem_m[int'(ld_addr) % DEPTH] = ld_data;
    cyc++;
  endtask

  task automatic applyStimulus(input logic rst, input logic l, input logic [7:0] la,
                               input logic [31:0] ldd, input logic fl, input logic rv,
                               input logic [7:0] ra, input logic rr);
    @(negedge clk);
    rst_n         = rst;
    ld_en         = l;
    ld_addr       = la;
    ld_data       = ldd;
    flush         = fl;
    bus.req_valid = rv;
    bus.req_addr  = ra;
    bus.rsp_ready = rr;
    #1;
    checkOutput();
    modelEdge();
  endtask

  task automatic idle(input logic rr);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 8'd0, rr);
  endtask

  task automatic fetch(input logic [7:0] a, input logic rr);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b1, a, rr);
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  initial begin
    int acc;
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'd0;
    bus.rsp_ready = 1'b0;

    tbl[0]  = mkv(1'b1, 8'd0, 32'hA0000000, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[1]  = mkv(1'b1, 8'd1, 32'hA0000001, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[2]  = mkv(1'b1, 8'd2, 32'hA0000002, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[3]  = mkv(1'b1, 8'd3, 32'hA0000003, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[4]  = mkv(1'b1, 8'd4, 32'hA0000004, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[5]  = mkv(1'b1, 8'd5, 32'hA0000005, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[6]  = mkv(1'b1, 8'd6, 32'hA0000006, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[7]  = mkv(1'b1, 8'd7, 32'hA0000007, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    tbl[8]  = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tbl[9]  = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 32'h0);
    tbl[10] = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 32'hA0000000);
    tbl[11] = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 32'hA0000001);
    tbl[12] = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 32'hA0000002);
    tbl[13] = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 32'hA0000003);
    tbl[14] = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 32'hA0000004);
    tbl[15] = mkv(1'b0, 8'd0, 32'h0, 1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 32'hA0000005);
    tbl[16] = mkv(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 32'hA0000006);
    tbl[17] = mkv(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 32'hA0000007);
    tbl[18] = mkv(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tbl[19] = mkv(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 32'h0);

    #2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd0, 1'b1);
      cmp1("reset_req_ready", bus.req_ready, 1'b0);
      cmp1("reset_rsp_valid", bus.rsp_valid, 1'b0);
      cmp32("reset_rsp_data", bus.rsp_data, 32'h0);
      cmp1("reset_rsp_err", bus.rsp_err, 1'b0);
    end

    // Program load then back-to-back fetch of words 0..7
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, tbl[i].ld_en, tbl[i].ld_addr, tbl[i].ld_data, 1'b0,
                    tbl[i].req_valid, tbl[i].req_addr, tbl[i].rsp_ready);
      cmp1($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].exp_ready);
      cmp1($sformatf("tbl%0d_valid", i), bus.rsp_valid, tbl[i].exp_valid);
      cmp32($sformatf("tbl%0d_data", i), bus.rsp_data, tbl[i].exp_data);
    end

    // Backpressure: only BUF_DEPTH accepts, a single pop frees one credit
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      fetch(8'(i), 1'b0);
      if (bus.req_ready) acc++;
    end
    cmp32("bp_accepts", 32'(acc), 32'd3);
    cmp1("bp_full_ready", bus.req_ready, 1'b0);
    idle(1'b1);
    cmp1("bp_pop_valid", bus.rsp_valid, 1'b1);
    cmp32("bp_pop_data", bus.rsp_data, 32'hA0000000);
    fetch(8'd3, 1'b0);
    cmp1("bp_reready", bus.req_ready, 1'b1);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Flush drops everything in flight
    fetch(8'd1, 1'b1);
    fetch(8'd2, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b1, 8'd9, 1'b1);
    cmp1("flush_ready", bus.req_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      cmp1("flush_after_valid", bus.rsp_valid, 1'b0);
    end
    fetch(8'd5, 1'b1);
    idle(1'b1);
    idle(1'b1);
    cmp1("flush_f5_valid", bus.rsp_valid, 1'b1);
    cmp32("flush_f5_data", bus.rsp_data, 32'hA0000005);
    idle(1'b1);
    cmp1("flush_f5_only", bus.rsp_valid, 1'b0);

    // Load blocks a concurrent fetch; the next fetch sees the new word
    applyStimulus(1'b1, 1'b1, 8'd3, 32'hDEADBEEF, 1'b0, 1'b1, 8'd3, 1'b1);
    cmp1("ld_blocks_ready", bus.req_ready, 1'b0);
    fetch(8'd3, 1'b1);
    cmp1("ld_next_ready", bus.req_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);
    cmp1("ld_new_valid", bus.rsp_valid, 1'b1);
    cmp32("ld_new_data", bus.rsp_data, 32'hDEADBEEF);
    idle(1'b1);

`ifdef IMEM_RANGE_CHECK_EN
    load(8'd47, 32'h5EED0047);
    load(8'd64, 32'hBAD0BAD0);
    fetch(8'd47, 1'b1);
    fetch(8'd48, 1'b1);
    fetch(8'd200, 1'b1);
    cmp32("rng_47_data", bus.rsp_data, 32'h5EED0047);
    cmp1("rng_47_err", bus.rsp_err, 1'b0);
    fetch(8'd0, 1'b1);
    cmp1("rng_48_valid", bus.rsp_valid, 1'b1);
    cmp32("rng_48_data", bus.rsp_data, 32'h0);
    cmp1("rng_48_err", bus.rsp_err, 1'b1);
    idle(1'b1);
    cmp32("rng_200_data", bus.rsp_data, 32'h0);
    cmp1("rng_200_err", bus.rsp_err, 1'b1);
    idle(1'b1);
    cmp32("rng_w0_kept", bus.rsp_data, 32'hA0000000);
    cmp1("rng_w0_err", bus.rsp_err, 1'b0);
    idle(1'b1);
`else
    fetch(8'd70, 1'b1);
    idle(1'b1);
    idle(1'b1);
    cmp32("alias_70_data", bus.rsp_data, 32'hA0000006);
    cmp1("alias_70_err", bus.rsp_err, 1'b0);
    idle(1'b1);
`endif

    // Reset with a full buffer, memory must survive
    fetch(8'd0, 1'b0);
    fetch(8'd1, 1'b0);
    fetch(8'd2, 1'b0);
    idle(1'b0);
    idle(1'b0);
    cmp1("rst_pre_valid", bus.rsp_valid, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd0, 1'b0);
    cmp1("rst_mid_ready", bus.req_ready, 1'b0);
    cmp1("rst_mid_valid", bus.rsp_valid, 1'b0);
    cmp32("rst_mid_data", bus.rsp_data, 32'h0);
    cmp1("rst_mid_err", bus.rsp_err, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 8'd0, 1'b1);
    fetch(8'd6, 1'b1);
    cmp1("rst_rel_ready", bus.req_ready, 1'b1);
    idle(1'b1);
    idle(1'b1);
    cmp1("rst_kept_valid", bus.rsp_valid, 1'b1);
    cmp32("rst_kept_data", bus.rsp_data, 32'hA0000006);
    idle(1'b1);

    // Randomized traffic over a fully loaded array
    for (int i = 0; i < DEPTH; i++) load(8'(i), $urandom);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b1,
                    $urandom_range(0, 99) < 8,
                    8'($urandom_range(0, 255)),
                    $urandom,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 70,
                    8'($urandom_range(0, 255)),
                    $urandom_range(0, 99) < 60);
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
